convolutor_addr_gen: RTL and testbench
======================================

Name: convolutor_addr_gen

Overview:
- Loop-index and address generator that answers the convolutor control FSM's strobes.
- Consumes size_enable_h, load_enable_h, ram_read_enable_h and addr_diag_count_h.
- Returns loop_bound_valid_h, half_loop_load and last_diag_h to the FSM, and drives the X/Y/Z memory addresses.
- Walks Z[k] = sum over j of X[j]*Y[k-j], for k = 0..N+M-2, with j limited to max(0,k-M+1)..min(k,N-1).

Parameters:
- ADDRW, 5, width of the X and Y addresses and of the size inputs; maximum size is 2**ADDRW-1.
- ZADDRW, ADDRW+1, width of the Z address.

Ports:
- clk  in  1  main clock; all logic is on the rising edge.
- rst_h  in  1  synchronous, active-high reset.
- size_enable_h  in  1  latch sizex_i and sizey_i.
- sizex_i  in  ADDRW  N, the length of X.
- sizey_i  in  ADDRW  M, the length of Y.
- load_enable_h  in  1  start a new convolution at k=0.
- ram_read_enable_h  in  1  consume the current (addr_x_o, addr_y_o) pair and advance j.
- addr_diag_count_h  in  1  advance k to the next output sample.
- addr_x_o  out  ADDRW  current j.
- addr_y_o  out  ADDRW  current k-j.
- addr_z_o  out  ZADDRW  current k.
- loop_bound_valid_h  out  1  current j lies within [lo,hi].
- half_loop_load  out  1  one-cycle pulse when k becomes M-1.
- last_diag_h  out  1  level; k == N+M-2.
- all_done_h  out  1  level; sequence finished or sizes invalid.

Behaviour:
- Reset: every output is 0, state S_IDLE, latched N and M are 0, k and j are 0.
- States:
  - S_IDLE: size_enable_h latches N and M, then -> S_SIZED. If N==0 or M==0, go -> S_DONE instead and assert all_done_h.
  - S_SIZED: load_enable_h sets k=0, j=lo(0)=0, then -> S_INNER.
  - S_INNER: loop_bound_valid_h=1.
    - ram_read_enable_h with j<hi: j increments.
    - ram_read_enable_h with j==hi: -> S_WAIT and loop_bound_valid_h drops on the next cycle.
  - S_WAIT: loop_bound_valid_h=0.
    - addr_diag_count_h with k<N+M-2: k increments, j=lo(k+1), -> S_INNER.
    - addr_diag_count_h with k==N+M-2: -> S_DONE.
  - S_DONE: all_done_h=1. load_enable_h restarts with the same sizes (-> S_INNER, k=0). size_enable_h relatches sizes (-> S_SIZED, or stays in S_DONE if a size is 0).
- Bounds: lo(k)=max(0,k-M+1), hi(k)=min(k,N-1). Compute in ZADDRW+1-bit signed arithmetic; no wrap.
- Addresses: registered and derived from the state registers. addr_y_o = k-j is truncated to ADDRW; it is always in range when bounds hold.
- Latency:
  - A strobe at edge t updates addresses and flags at edge t+1.
  - The FSM samples the address pair in the same cycle it asserts ram_read_enable_h.
- half_loop_load: pulses for one cycle in the cycle after k is set to M-1. When M==1 this is immediately after load_enable_h.
- last_diag_h: high whenever k==N+M-2 in S_INNER or S_WAIT.
- Priority when strobes coincide: rst_h > load_enable_h > size_enable_h > addr_diag_count_h > ram_read_enable_h.
- Ignored strobes:
  - size_enable_h in S_INNER or S_WAIT.
  - ram_read_enable_h outside S_INNER.
  - addr_diag_count_h in S_INNER; the FSM must finish the inner loop first. The bench checks this with an assertion.
- load_enable_h in S_INNER or S_WAIT aborts the current run and restarts at k=0 without relatching sizes.
- rst_h mid-run: back to S_IDLE next edge; sizes are cleared.

Decomposition:
- convolutor_pkg holds:
  - the ADDRW and ZADDRW defaults;
  - the typedef enum addr_gen_state_t {S_IDLE, S_SIZED, S_INNER, S_WAIT, S_DONE};
  - the typedefs addr_t and zaddr_t.
- One combinational sub-module, convolutor_bound_calc: inputs k, N, M; outputs lo, hi and is_last. It is reused by the bench's reference model.

Test Plan:
- Nominal N=3, M=2: size_enable_h, then load_enable_h, then the FSM-style strobe sequence.
  - (x,y) pairs per k: k0 (0,0); k1 (0,1),(1,0); k2 (1,1),(2,0); k3 (2,1). That is 6 reads and 4 diag steps.
  - half_loop_load pulses exactly once, at addr_z_o=1.
  - last_diag_h is high at k=3; all_done_h=1 after the final addr_diag_count_h.
- Degenerate N=1, M=1: a single pair (0,0).
  - half_loop_load pulses right after load.
  - last_diag_h=1 immediately.
  - all_done_h=1 after one read and one diag strobe.
- Zero size N=0, M=4: size_enable_h -> all_done_h=1 next cycle; a following load_enable_h is accepted but all_done_h stays 1.
- Max size N=M=31: full sweep, 961 reads and 61 k-values.
  - addr_z_o reaches 60 without overflow.
  - Compare every pair against convolutor_bound_calc.
- Simultaneous strobes: in S_INNER at k=1, j=0, assert load_enable_h together with ram_read_enable_h -> next cycle k=0, j=0, loop_bound_valid_h=1.
- Reset mid-run: assert rst_h at k=2 -> all outputs 0 next edge. A load_enable_h without size_enable_h is then ignored (state stays S_IDLE).

Source files
------------

// File: rtl/convolutor_pkg.sv
// Shared widths, FSM state encoding and address types for the convolutor address generator.
package convolutor_pkg;

  localparam int DEF_ADDRW  = 5;
  localparam int DEF_ZADDRW = DEF_ADDRW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIZED,
    S_INNER,
    S_WAIT,
    S_DONE
  } addr_gen_state_t;

  typedef logic [DEF_ADDRW-1:0]  addr_t;
  typedef logic [DEF_ZADDRW-1:0] zaddr_t;

endpackage

// File: rtl/convolutor_addr_gen_if.sv
// Strobe/address bundle between the convolutor control FSM (master) and the address generator (slave).
interface convolutor_addr_gen_if
  import convolutor_pkg::*;
#(
  parameter int ADDRW  = DEF_ADDRW,
  parameter int ZADDRW = DEF_ZADDRW
);

  logic              size_enable_h;
  logic [ADDRW-1:0]  sizex_i;
  logic [ADDRW-1:0]  sizey_i;
  logic              load_enable_h;
  logic              ram_read_enable_h;
  logic              addr_diag_count_h;
  logic [ADDRW-1:0]  addr_x_o;
  logic [ADDRW-1:0]  addr_y_o;
  logic [ZADDRW-1:0] addr_z_o;
  logic              loop_bound_valid_h;
  logic              half_loop_load;
  logic              last_diag_h;
  logic              all_done_h;

  modport master (
    output size_enable_h, sizex_i, sizey_i, load_enable_h, ram_read_enable_h, addr_diag_count_h,
    input  addr_x_o, addr_y_o, addr_z_o, loop_bound_valid_h, half_loop_load, last_diag_h, all_done_h
  );

  modport slave (
    input  size_enable_h, sizex_i, sizey_i, load_enable_h, ram_read_enable_h, addr_diag_count_h,
    output addr_x_o, addr_y_o, addr_z_o, loop_bound_valid_h, half_loop_load, last_diag_h, all_done_h
  );

endinterface

// File: rtl/convolutor_bound_calc.sv
// Combinational inner-loop bounds for output sample k: lo=max(0,k-M+1), hi=min(k,N-1), is_last=(k==N+M-2).
module convolutor_bound_calc
  import convolutor_pkg::*;
#(
  parameter int ADDRW  = DEF_ADDRW,
  parameter int ZADDRW = DEF_ZADDRW
) (
  input  logic [ZADDRW-1:0] i_k,
  input  logic [ADDRW-1:0]  i_n,
  input  logic [ADDRW-1:0]  i_m,
  output logic [ADDRW-1:0]  o_lo,
  output logic [ADDRW-1:0]  o_hi,
  output logic              o_is_last
);

  localparam int SW = ZADDRW + 1;

  logic signed [SW-1:0] w_k;
  logic signed [SW-1:0] w_n;
  logic signed [SW-1:0] w_m;
  logic signed [SW-1:0] w_lo;
  logic signed [SW-1:0] w_nm1;
  logic signed [SW-1:0] w_last_k;

  assign w_k      = $signed(SW'(i_k));
  assign w_n      = $signed(SW'(i_n));
  assign w_m      = $signed(SW'(i_m));
  // One extra sign bit keeps k-M+1 and N-1 from wrapping when they go negative
  assign w_lo     = w_k - w_m + $signed(SW'(1));
  assign w_nm1    = w_n - $signed(SW'(1));
  assign w_last_k = w_n + w_m - $signed(SW'(2));

  assign o_lo      = w_lo[SW-1] ? '0 : ADDRW'(w_lo);
  assign o_hi      = (w_k < w_nm1) ? ADDRW'(w_k) : ADDRW'(w_nm1);
  assign o_is_last = (w_k == w_last_k);

endmodule

// File: rtl/convolutor_addr_gen.sv
// Walks (j, k-j, k) for Z[k] = sum X[j]*Y[k-j]; strobes sampled on an edge update every output on that edge.
// No backpressure: strobes that do not apply to the current state are dropped.
module convolutor_addr_gen
  import convolutor_pkg::*;
#(
  parameter int ADDRW  = DEF_ADDRW,
  parameter int ZADDRW = DEF_ZADDRW
) (
  input  logic                 clk,
  input  logic                 rst_h,
  convolutor_addr_gen_if.slave bus
);

  addr_gen_state_t   r_state;
  logic [ADDRW-1:0]  r_n;
  logic [ADDRW-1:0]  r_m;
  logic [ADDRW-1:0]  r_j;
  logic [ADDRW-1:0]  r_y;
  logic [ZADDRW-1:0] r_k;
  logic              r_valid;
  logic              r_half;
  logic              r_last;
  logic              r_done;

  logic [ZADDRW-1:0] w_k1;
  logic [ZADDRW-1:0] w_bk;
  logic [ADDRW-1:0]  w_lo;
  logic [ADDRW-1:0]  w_hi;
  logic              w_is_last;
  logic              w_sizes_ok;
  logic              w_new_zero;
  logic              w_can_size;

  assign w_k1       = r_k + ZADDRW'(1);
  assign w_sizes_ok = (r_n != '0) && (r_m != '0);
  assign w_new_zero = (bus.sizex_i == '0) || (bus.sizey_i == '0);
  assign w_can_size = (r_state != S_INNER) && (r_state != S_WAIT);

  // One shared calculator: k=0 for a restart, k+1 while waiting to step, else the current k for hi
  assign w_bk = bus.load_enable_h ? '0 : ((r_state == S_WAIT) ? w_k1 : r_k);

  convolutor_bound_calc #(
    .ADDRW (ADDRW),
    .ZADDRW(ZADDRW)
  ) u_bound (
    .i_k      (w_bk),
    .i_n      (r_n),
    .i_m      (r_m),
    .o_lo     (w_lo),
    .o_hi     (w_hi),
    .o_is_last(w_is_last)
  );

  always_ff @(posedge clk) begin
    if (rst_h) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_m     <= '0;
      r_j     <= '0;
      r_y     <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_half  <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_half <= 1'b0;
      if (bus.load_enable_h && (r_state != S_IDLE)) begin
        // With a zero size latched the restart is swallowed and the block stays done
        if (w_sizes_ok) begin
          r_state <= S_INNER;
          r_k     <= '0;
          r_j     <= '0;
          r_y     <= '0;
          r_valid <= 1'b1;
          r_last  <= w_is_last;
          r_done  <= 1'b0;
          r_half  <= (r_m == ADDRW'(1));
        end
      end else if (bus.size_enable_h && w_can_size) begin
        r_n     <= bus.sizex_i;
        r_m     <= bus.sizey_i;
        r_k     <= '0;
        r_j     <= '0;
        r_y     <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_state <= w_new_zero ? S_DONE : S_SIZED;
        r_done  <= w_new_zero;
      end else if (bus.addr_diag_count_h && (r_state == S_WAIT)) begin
        if (r_last) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_last  <= 1'b0;
        end else begin
          r_state <= S_INNER;
          r_k     <= w_k1;
          r_j     <= w_lo;
          r_y     <= ADDRW'(w_k1 - ZADDRW'(w_lo));
          r_valid <= 1'b1;
          r_last  <= w_is_last;
          r_half  <= (w_k1 == (ZADDRW'(r_m) - ZADDRW'(1)));
        end
      end else if (bus.ram_read_enable_h && (r_state == S_INNER)) begin
        if (r_j == w_hi) begin
          r_state <= S_WAIT;
          r_valid <= 1'b0;
        end else begin
          r_j <= r_j + ADDRW'(1);
          r_y <= r_y - ADDRW'(1);
        end
      end
    end
  end

  assign bus.addr_x_o           = r_j;
  assign bus.addr_y_o           = r_y;
  assign bus.addr_z_o           = r_k;
  assign bus.loop_bound_valid_h = r_valid;
  assign bus.half_loop_load     = r_half;
  assign bus.last_diag_h        = r_last;
  assign bus.all_done_h         = r_done;

endmodule

// File: tb/tb_convolutor_addr_gen.sv
// Randomised FSM-style driver with a queue scoreboard fed by an arithmetic model of the convolution walk.
module tb_convolutor_addr_gen;
  import convolutor_pkg::*;

  typedef struct {
    int x;
    int y;
    int z;
    int last;
  } pair_t;

  logic clk;
  logic rst_h;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b1;

  pair_t pair_q[$];
  int    half_q[$];
  pair_t mon_e;
  int    mon_h;

  zaddr_t bc_k;
  addr_t  bc_n;
  addr_t  bc_m;
  addr_t  bc_lo;
  addr_t  bc_hi;
  logic   bc_last;

  int tn, tm, lo_e, hi_e, cyc;

  convolutor_addr_gen_if bus ();

  convolutor_addr_gen dut (
    .clk  (clk),
    .rst_h(rst_h),
    .bus  (bus)
  );

  convolutor_bound_calc #(
    .ADDRW (DEF_ADDRW),
    .ZADDRW(DEF_ZADDRW)
  ) u_ref_bound (
    .i_k      (bc_k),
    .i_n      (bc_n),
    .i_m      (bc_m),
    .o_lo     (bc_lo),
    .o_hi     (bc_hi),
    .o_is_last(bc_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic idle_strobes();
    bus.size_enable_h     = 1'b0;
    bus.load_enable_h     = 1'b0;
    bus.ram_read_enable_h = 1'b0;
    bus.addr_diag_count_h = 1'b0;
  endtask

  // Reference model: enumerate every (j, k-j, k) the convolution sum touches
  task automatic push_expect(input int n, input int m);
    int lo;
    int hi;
    pair_t p;
    for (int k = 0; k <= n + m - 2; k++) begin
      lo = (k - m + 1 > 0) ? k - m + 1 : 0;
      hi = (k < n - 1) ? k : n - 1;
      if (k == m - 1) half_q.push_back(k);
      for (int j = lo; j <= hi; j++) begin
        p.x = j;
        p.y = k - j;
        p.z = k;
        p.last = (k == n + m - 2) ? 1 : 0;
        pair_q.push_back(p);
      end
    end
  endtask

  task automatic set_sizes(input int n, input int m);
    @(negedge clk);
    idle_strobes();
    bus.size_enable_h = 1'b1;
    bus.sizex_i = addr_t'(n);
    bus.sizey_i = addr_t'(m);
    @(negedge clk);
    idle_strobes();
    #1;
    chk("sized_all_done", bus.all_done_h, (n == 0 || m == 0) ? 1 : 0);
  endtask

  task automatic do_load();
    @(negedge clk);
    idle_strobes();
    bus.load_enable_h = 1'b1;
  endtask

  task automatic drive_loop(input int n, input int m);
    int diags;
    int cyc_l;
    int limit;
    diags = 0;
    cyc_l = 0;
    limit = 4 * n * m + 8 * (n + m) + 50;
    while (diags < n + m - 1 && cyc_l < limit) begin
      @(negedge clk);
      cyc_l++;
      idle_strobes();
      if (bus.loop_bound_valid_h) begin
        if ($urandom_range(3) != 0) begin
          bus.ram_read_enable_h = 1'b1;
          if ($urandom_range(7) == 0) begin
            bus.size_enable_h = 1'b1;
            bus.sizex_i = addr_t'($urandom);
            bus.sizey_i = addr_t'($urandom);
          end
        end
      end else if ($urandom_range(3) != 0) begin
        bus.addr_diag_count_h = 1'b1;
        diags++;
      end else begin
        bus.ram_read_enable_h = 1'($urandom_range(1));
      end
    end
    @(negedge clk);
    idle_strobes();
    #1;
    checks++;
    if (cyc_l >= limit) begin
      failures++;
      $display("FAIL drive_timeout cycles=%0d limit=%0d", cyc_l, limit);
      pair_q.delete();
      half_q.delete();
    end
  endtask

  task automatic post_run(input string tag);
    chk({tag, "_all_done"}, bus.all_done_h, 1);
    chk({tag, "_valid_low"}, bus.loop_bound_valid_h, 0);
    chk({tag, "_last_low"}, bus.last_diag_h, 0);
    chk({tag, "_pairs_left"}, pair_q.size(), 0);
    chk({tag, "_halves_left"}, half_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_x"}, bus.addr_x_o, 0);
    chk({tag, "_y"}, bus.addr_y_o, 0);
    chk({tag, "_z"}, bus.addr_z_o, 0);
    chk({tag, "_valid"}, bus.loop_bound_valid_h, 0);
    chk({tag, "_half"}, bus.half_loop_load, 0);
    chk({tag, "_last"}, bus.last_diag_h, 0);
    chk({tag, "_done"}, bus.all_done_h, 0);
  endtask

  // Monitor: a pair is consumed when read meets valid and no higher-priority restart
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && !rst_h) begin
        if (bus.half_loop_load) begin
          if (half_q.size() == 0) begin
            chk("half_unexpected_z", bus.addr_z_o, -1);
          end else begin
            mon_h = half_q.pop_front();
            chk("half_z", bus.addr_z_o, mon_h);
          end
        end
        if (bus.ram_read_enable_h && bus.loop_bound_valid_h && !bus.load_enable_h) begin
          if (pair_q.size() == 0) begin
            chk("pair_unexpected_z", bus.addr_z_o, -1);
          end else begin
            mon_e = pair_q.pop_front();
            chk("pair_x", bus.addr_x_o, mon_e.x);
            chk("pair_y", bus.addr_y_o, mon_e.y);
            chk("pair_z", bus.addr_z_o, mon_e.z);
            chk("pair_last", bus.last_diag_h, mon_e.last);
            chk("pair_not_done", bus.all_done_h, 0);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_h) begin
      assert (!(bus.addr_diag_count_h && bus.loop_bound_valid_h))
      else $error("FAIL diag_strobe_inside_inner_loop");
    end
  end

  initial begin
    rst_h = 1'b1;
    idle_strobes();
    bus.sizex_i = '0;
    bus.sizey_i = '0;
    bc_k = '0;
    bc_n = '0;
    bc_m = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_h = 1'b0;

    for (int s = 0; s < 2; s++) begin
      tn = (s == 0) ? 31 : 5;
      tm = (s == 0) ? 31 : 9;
      bc_n = addr_t'(tn);
      bc_m = addr_t'(tm);
      for (int k = 0; k <= tn + tm - 2; k++) begin
        bc_k = zaddr_t'(k);
        #1;
        lo_e = (k - tm + 1 > 0) ? k - tm + 1 : 0;
        hi_e = (k < tn - 1) ? k : tn - 1;
        chk("bound_lo", bc_lo, lo_e);
        chk("bound_hi", bc_hi, hi_e);
        chk("bound_last", bc_last, (k == tn + tm - 2) ? 1 : 0);
      end
    end

    set_sizes(3, 2);
    push_expect(3, 2);
    chk("nominal_pair_count", pair_q.size(), 6);
    do_load();
    drive_loop(3, 2);
    post_run("nominal");

    set_sizes(1, 1);
    push_expect(1, 1);
    do_load();
    drive_loop(1, 1);
    post_run("degenerate");

    set_sizes(0, 4);
    do_load();
    @(negedge clk);
    idle_strobes();
    #1;
    chk("zero_done_after_load", bus.all_done_h, 1);
    chk("zero_valid_after_load", bus.loop_bound_valid_h, 0);

    set_sizes(31, 31);
    push_expect(31, 31);
    chk("max_pair_count", pair_q.size(), 961);
    do_load();
    drive_loop(31, 31);
    post_run("max");
    chk("max_final_z", bus.addr_z_o, 60);

    for (int r = 0; r < 10; r++) begin
      if (r == 0 || $urandom_range(2) != 0) begin
        tn = $urandom_range(12, 1);
        tm = $urandom_range(12, 1);
        set_sizes(tn, tm);
      end
      push_expect(tn, tm);
      do_load();
      drive_loop(tn, tm);
      post_run("random");
    end

    set_sizes(3, 2);
    begin
      pair_t p0;
      p0.x = 0;
      p0.y = 0;
      p0.z = 0;
      p0.last = 0;
      pair_q.push_back(p0);
    end
    half_q.push_back(1);
    do_load();
    @(negedge clk);
    idle_strobes();
    bus.ram_read_enable_h = 1'b1;
    @(negedge clk);
    idle_strobes();
    bus.addr_diag_count_h = 1'b1;
    @(negedge clk);
    idle_strobes();
    #1;
    chk("simul_pre_z", bus.addr_z_o, 1);
    chk("simul_pre_x", bus.addr_x_o, 0);
    bus.load_enable_h = 1'b1;
    bus.ram_read_enable_h = 1'b1;
    @(negedge clk);
    idle_strobes();
    #1;
    chk("simul_x", bus.addr_x_o, 0);
    chk("simul_y", bus.addr_y_o, 0);
    chk("simul_z", bus.addr_z_o, 0);
    chk("simul_valid", bus.loop_bound_valid_h, 1);
    push_expect(3, 2);
    drive_loop(3, 2);
    post_run("simul");

    mon_en = 1'b0;
    set_sizes(4, 3);
    do_load();
    cyc = 0;
    while (bus.addr_z_o != 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      idle_strobes();
      if (bus.loop_bound_valid_h) bus.ram_read_enable_h = 1'b1;
      else bus.addr_diag_count_h = 1'b1;
    end
    chk("rst_reach_k2", bus.addr_z_o, 2);
    idle_strobes();
    rst_h = 1'b1;
    @(negedge clk);
    rst_h = 1'b0;
    #1;
    check_all_zero("midrun_rst");
    do_load();
    @(negedge clk);
    idle_strobes();
    #1;
    check_all_zero("load_after_rst");
    mon_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
